// File: rtl/umi_req_arbiter.sv
`timescale 1ns/1ps
// umi_req_arbiter: shares one UMI device port between N host request channels.
// Requests are granted round-robin and a multi-beat transaction keeps the grant
// until its EOM beat. Each response-expecting transaction leaves its grant index
// in an in-order FIFO, and device responses are steered back using that FIFO.
module umi_req_arbiter #(
    parameter int N     = 4,
    parameter int CW    = 32,
    parameter int AW    = 64,
    parameter int DW    = 256,
    parameter int DEPTH = 8
) (
    input  logic            clk,
    input  logic            nreset,
    // host request channels
    input  logic [N-1:0]    host_req_valid,
    input  logic [N*CW-1:0] host_req_cmd,
    input  logic [N*AW-1:0] host_req_dstaddr,
    input  logic [N*AW-1:0] host_req_srcaddr,
    input  logic [N*DW-1:0] host_req_data,
    output logic [N-1:0]    host_req_ready,
    // host response channels (payload broadcast, valid steered)
    output logic [N-1:0]    host_resp_valid,
    output logic [N*CW-1:0] host_resp_cmd,
    output logic [N*AW-1:0] host_resp_dstaddr,
    output logic [N*AW-1:0] host_resp_srcaddr,
    output logic [N*DW-1:0] host_resp_data,
    input  logic [N-1:0]    host_resp_ready,
    // device request channel
    output logic            dev_req_valid,
    output logic [CW-1:0]   dev_req_cmd,
    output logic [AW-1:0]   dev_req_dstaddr,
    output logic [AW-1:0]   dev_req_srcaddr,
    output logic [DW-1:0]   dev_req_data,
    input  logic            dev_req_ready,
    // device response channel
    input  logic            dev_resp_valid,
    input  logic [CW-1:0]   dev_resp_cmd,
    input  logic [AW-1:0]   dev_resp_dstaddr,
    input  logic [AW-1:0]   dev_resp_srcaddr,
    input  logic [DW-1:0]   dev_resp_data,
    output logic            dev_resp_ready,
    // status
    output logic            orphan_err
);

    localparam int GW   = (N > 1) ? $clog2(N) : 1;
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);

    // opcodes that expect a response from the device
    localparam logic [4:0] OP_READ   = 5'h01;
    localparam logic [4:0] OP_WRITE  = 5'h03;
    localparam logic [4:0] OP_ATOMIC = 5'h09;

    // arbitration state
    logic [GW-1:0]   rr_ptr;
    logic [GW-1:0]   gnt_q;
    logic            lock;
    logic [GW-1:0]   gnt;
    logic            scan_found;
    int              scan_idx;

    // response-tracking FIFO
    logic [GW-1:0]   fifo_mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CNTW-1:0] count;
    logic [GW-1:0]   head;
    logic            fifo_nonempty;
    logic            fifo_full;

    // request-beat decode
    logic [CW-1:0]   req_cmd;
    logic            req_tracked;
    logic            req_eom;
    logic            stall;
    logic            req_fire;
    logic            push;
    logic            pop;

    // Pick the granted host: held while locked, otherwise first valid from rr_ptr
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        gnt        = rr_ptr;
        scan_found = 1'b0;
        scan_idx   = 0;
        if (lock) begin
            gnt = gnt_q;
        end else begin
            for (int k = 0; k < N; k++) begin
                scan_idx = (int'(rr_ptr) + k) % N;
                if (!scan_found && host_req_valid[scan_idx]) begin
                    gnt        = GW'(scan_idx);
                    scan_found = 1'b1;
                end
            end
        end
    end

    // Zero-latency request mux from the granted host to the device
    assign req_cmd         = host_req_cmd[gnt*CW +: CW];
    assign dev_req_cmd     = req_cmd;
    assign dev_req_dstaddr = host_req_dstaddr[gnt*AW +: AW];
    assign dev_req_srcaddr = host_req_srcaddr[gnt*AW +: AW];
    assign dev_req_data    = host_req_data[gnt*DW +: DW];

    assign req_tracked = (req_cmd[4:0] == OP_READ)  ||
                         (req_cmd[4:0] == OP_WRITE) ||
                         (req_cmd[4:0] == OP_ATOMIC);
    assign req_eom     = req_cmd[22];

    // A tracked final beat needs a FIFO slot; fullness uses the registered count only
    assign fifo_full     = (count == CNTW'(DEPTH));
    assign fifo_nonempty = (count != '0);
    assign stall         = req_tracked & req_eom & fifo_full;

    assign dev_req_valid = nreset & host_req_valid[gnt] & ~stall;
    assign req_fire      = dev_req_valid & dev_req_ready;
    assign push          = req_fire & req_tracked & req_eom;

    // Only the granted host sees ready
    always_comb begin
        host_req_ready      = '0;
        host_req_ready[gnt] = nreset & dev_req_ready & ~stall;
    end

    // Response routing: the FIFO head names the host that owns the next response
    assign head           = fifo_mem[rd_ptr];
    assign dev_resp_ready = nreset & fifo_nonempty & host_resp_ready[head];
    assign pop            = dev_resp_valid & dev_resp_ready & dev_resp_cmd[22];

    // Steer response valid to the head host only
    always_comb begin
        host_resp_valid = '0;
        if (nreset && fifo_nonempty) begin
            host_resp_valid[head] = dev_resp_valid;
        end
    end

    assign host_resp_cmd     = {N{dev_resp_cmd}};
    assign host_resp_dstaddr = {N{dev_resp_dstaddr}};
    assign host_resp_srcaddr = {N{dev_resp_srcaddr}};
    assign host_resp_data    = {N{dev_resp_data}};

    // Lock the grant mid-transaction; rotate priority past the winner on EOM
    always_ff @(posedge clk or negedge nreset) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!nreset) begin
            rr_ptr <= '0;
            gnt_q  <= '0;
            lock   <= 1'b0;
        end else if (req_fire) begin
            if (req_eom) begin
                lock   <= 1'b0;
                rr_ptr <= (gnt == GW'(N - 1)) ? '0 : gnt + GW'(1);
            end else begin
                lock   <= 1'b1;
                gnt_q  <= gnt;
            end
        end
    end

    // Record the grant index of each tracked transaction at its final beat
    always_ff @(posedge clk) begin
        // NOTE: FIFO storage is not reset; count and pointers decide which entries are live.
        if (push) begin
            fifo_mem[wr_ptr] <= gnt;
        end
    end

    // FIFO pointers and occupancy; push and pop together leave count unchanged
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky flag for a device response that no tracked request is waiting for
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            orphan_err <= 1'b0;
        end else if (dev_resp_valid && !fifo_nonempty) begin
            orphan_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_umi_req_arbiter.sv
`timescale 1ns/1ps
// tb_umi_req_arbiter: directed scenarios plus randomized traffic, every cycle
// compared against a transaction-level model (host queues, round-robin pointer,
// outstanding-response queue).
module tb_umi_req_arbiter;

    localparam int N     = 4;
    localparam int CW    = 32;
    localparam int AW    = 64;
    localparam int DW    = 256;
    localparam int DEPTH = 8;
    localparam int NTXN  = 10000;

    typedef struct packed {
        logic [CW-1:0] cmd;
        logic [AW-1:0] dst;
        logic [AW-1:0] src;
        logic [DW-1:0] data;
    } beat_t;

    typedef struct packed {
        int host;
        int seq;
        int beats;
    } rsp_t;

    logic            clk = 1'b0;
    logic            nreset;
    logic [N-1:0]    host_req_valid;
    logic [N*CW-1:0] host_req_cmd;
    logic [N*AW-1:0] host_req_dstaddr;
    logic [N*AW-1:0] host_req_srcaddr;
    logic [N*DW-1:0] host_req_data;
    logic [N-1:0]    host_req_ready;
    logic [N-1:0]    host_resp_valid;
    logic [N*CW-1:0] host_resp_cmd;
    logic [N*AW-1:0] host_resp_dstaddr;
    logic [N*AW-1:0] host_resp_srcaddr;
    logic [N*DW-1:0] host_resp_data;
    logic [N-1:0]    host_resp_ready;
    logic            dev_req_valid;
    logic [CW-1:0]   dev_req_cmd;
    logic [AW-1:0]   dev_req_dstaddr;
    logic [AW-1:0]   dev_req_srcaddr;
    logic [DW-1:0]   dev_req_data;
    logic            dev_req_ready;
    logic            dev_resp_valid;
    logic [CW-1:0]   dev_resp_cmd;
    logic [AW-1:0]   dev_resp_dstaddr;
    logic [AW-1:0]   dev_resp_srcaddr;
    logic [DW-1:0]   dev_resp_data;
    logic            dev_resp_ready;
    logic            orphan_err;

    umi_req_arbiter #(.N(N), .CW(CW), .AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk               (clk),
        .nreset            (nreset),
        .host_req_valid    (host_req_valid),
        .host_req_cmd      (host_req_cmd),
        .host_req_dstaddr  (host_req_dstaddr),
        .host_req_srcaddr  (host_req_srcaddr),
        .host_req_data     (host_req_data),
        .host_req_ready    (host_req_ready),
        .host_resp_valid   (host_resp_valid),
        .host_resp_cmd     (host_resp_cmd),
        .host_resp_dstaddr (host_resp_dstaddr),
        .host_resp_srcaddr (host_resp_srcaddr),
        .host_resp_data    (host_resp_data),
        .host_resp_ready   (host_resp_ready),
        .dev_req_valid     (dev_req_valid),
        .dev_req_cmd       (dev_req_cmd),
        .dev_req_dstaddr   (dev_req_dstaddr),
        .dev_req_srcaddr   (dev_req_srcaddr),
        .dev_req_data      (dev_req_data),
        .dev_req_ready     (dev_req_ready),
        .dev_resp_valid    (dev_resp_valid),
        .dev_resp_cmd      (dev_resp_cmd),
        .dev_resp_dstaddr  (dev_resp_dstaddr),
        .dev_resp_srcaddr  (dev_resp_srcaddr),
        .dev_resp_data     (dev_resp_data),
        .dev_resp_ready    (dev_resp_ready),
        .orphan_err        (orphan_err)
    );

    always #5 clk = ~clk;

    // bench state: stimulus queues and the reference model
    beat_t hq [N][$];          // pending request beats per host
    int    next_seq [N];
    int    exp_resp [N][$];    // per-host sequence numbers still owed a response
    rsp_t  dq [$];             // device responder work list
    int    resp_beat_done;
    int    m_outq [$];         // hosts of outstanding tracked transactions, oldest first
    int    m_rr;
    bit    m_lock;
    int    m_lock_host;
    bit    m_orphan;

    bit    in_reset;
    bit    rnd;
    bit    dreq_rdy;
    bit    inject_orphan;
    int    resp_budget;        // -1 unlimited, else number of responses allowed
    int    cyc;
    int    pop_cyc;
    int    n_trk;
    int    n_rsp;
    int    acc_log [$];
    int    acc_cyc [$];
    int    resp_log [$];

    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit is_tracked(input logic [4:0] op);
        return (op == 5'h01) || (op == 5'h03) || (op == 5'h09);
    endfunction

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic bit pending();
        bit p = (m_outq.size() != 0);
        for (int h = 0; h < N; h++) begin
            if (hq[h].size() != 0) p = 1'b1;
        end
        return p;
    endfunction

    task automatic add_txn(input int h, input logic [4:0] op, input int nb);
        beat_t b;
        for (int i = 0; i < nb; i++) begin
            b.cmd         = $urandom;
            b.cmd[4:0]    = op;
            b.cmd[22]     = (i == nb - 1);
            b.dst         = {$urandom, $urandom};
            b.src         = {$urandom, $urandom};
            b.data        = {$urandom, $urandom, $urandom, $urandom,
                             $urandom, $urandom, $urandom, $urandom};
            b.data[15:0]  = 16'(next_seq[h]);
            b.data[23:16] = 8'(h);
            b.data[31:24] = 8'(i);
            hq[h].push_back(b);
        end
        next_seq[h]++;
    endtask

    task automatic clear_logs();
        acc_log.delete();
        acc_cyc.delete();
        resp_log.delete();
    endtask

    // Drive all DUT inputs from bench state (called just after a rising edge)
    task automatic drive();
        for (int h = 0; h < N; h++) begin
            if (in_reset) begin
                host_req_valid[h] = 1'b1;
                host_req_cmd[h*CW +: CW] = $urandom;
            end else if (hq[h].size() != 0) begin
                host_req_valid[h]             = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                host_req_cmd[h*CW +: CW]      = hq[h][0].cmd;
                host_req_dstaddr[h*AW +: AW]  = hq[h][0].dst;
                host_req_srcaddr[h*AW +: AW]  = hq[h][0].src;
                host_req_data[h*DW +: DW]     = hq[h][0].data;
            end else begin
                host_req_valid[h]        = 1'b0;
                host_req_cmd[h*CW +: CW] = $urandom;
            end
            host_resp_ready[h] = in_reset || !rnd || ($urandom_range(0, 3) != 0);
        end
        dev_req_ready    = in_reset ? 1'b1 : (rnd ? ($urandom_range(0, 7) != 0) : dreq_rdy);
        dev_resp_valid   = 1'b0;
        dev_resp_cmd     = $urandom;
        dev_resp_dstaddr = {$urandom, $urandom};
        dev_resp_srcaddr = {$urandom, $urandom};
        dev_resp_data    = {$urandom, $urandom, $urandom, $urandom,
                            $urandom, $urandom, $urandom, $urandom};
        if (in_reset) begin
            dev_resp_valid = 1'b1;
        end else if (inject_orphan) begin
            dev_resp_valid   = 1'b1;
            dev_resp_cmd[22] = 1'b1;
        end else if (resp_budget != 0 && dq.size() != 0) begin
            dev_resp_valid        = rnd ? ($urandom_range(0, 4) != 0) : 1'b1;
            dev_resp_cmd[4:0]     = 5'h02;
            dev_resp_cmd[22]      = (resp_beat_done == dq[0].beats - 1);
            dev_resp_data[15:0]   = 16'(dq[0].seq);
            dev_resp_data[23:16]  = 8'(dq[0].host);
        end
    endtask

    // Compare DUT outputs with the model, then advance the model by this cycle's handshakes
    task automatic evaluate();
        int    cnt0;
        int    g;
        int    h;
        int    seq;
        int    nb;
        bit    any;
        bit    trk;
        bit    eom;
        bit    stall;
        bit    rsp_acc;
        logic  exp_dr;
        logic [N-1:0] exp_rdy;
        logic [N-1:0] exp_hv;
        beat_t b;
        cyc++;
        if (in_reset) begin
            check("rst_dev_req_valid",   dev_req_valid,   '0);
            check("rst_host_req_ready",  host_req_ready,  '0);
            check("rst_host_resp_valid", host_resp_valid, '0);
            check("rst_dev_resp_ready",  dev_resp_ready,  '0);
            check("rst_orphan_err",      orphan_err,      '0);
            return;
        end
        cnt0 = m_outq.size();

        // response side, judged on the outstanding queue before this cycle's updates
        exp_hv = '0;
        exp_dr = 1'b0;
        h      = -1;
        if (cnt0 > 0) begin
            h         = m_outq[0];
            exp_hv[h] = dev_resp_valid;
            exp_dr    = host_resp_ready[h];
        end
        check("host_resp_valid", host_resp_valid, exp_hv);
        check("dev_resp_ready",  dev_resp_ready,  exp_dr);
        check("orphan_err",      orphan_err,      m_orphan);
        rsp_acc = dev_resp_valid && exp_dr;
        if (rsp_acc) begin
            check("resp_data_bcast", host_resp_data[h*DW +: DW], dev_resp_data);
            check("resp_cmd_bcast",  host_resp_cmd[h*CW +: CW],  dev_resp_cmd);
            check("resp_order",      dev_resp_data[15:0],        exp_resp[h][0]);
        end
        if (cnt0 == 0 && dev_resp_valid) m_orphan = 1'b1;

        // request side: round-robin from m_rr, or the locked host
        any = 1'b0;
        g   = m_rr;
        if (m_lock) begin
            g   = m_lock_host;
            any = host_req_valid[g];
        end else begin
            for (int k = 0; k < N; k++) begin
                if (!any && host_req_valid[(m_rr + k) % N]) begin
                    g   = (m_rr + k) % N;
                    any = 1'b1;
                end
            end
        end
        trk = 1'b0;
        eom = 1'b0;
        b   = '0;
        if (any) begin
            b   = hq[g][0];
            trk = is_tracked(b.cmd[4:0]);
            eom = b.cmd[22];
        end
        stall   = trk && eom && (cnt0 == DEPTH);
        exp_rdy = '0;
        if (any && !stall) exp_rdy[g] = dev_req_ready;
        check("dev_req_valid",  dev_req_valid, any && !stall);
        check("host_req_ready", host_req_ready & host_req_valid, exp_rdy);
        if (any && !stall) begin
            check("dev_req_cmd",     dev_req_cmd,     b.cmd);
            check("dev_req_dstaddr", dev_req_dstaddr, b.dst);
            check("dev_req_srcaddr", dev_req_srcaddr, b.src);
            check("dev_req_data",    dev_req_data,    b.data);
        end

        // apply response beat
        if (rsp_acc) begin
            if (dev_resp_cmd[22]) begin
                void'(m_outq.pop_front());
                void'(exp_resp[h].pop_front());
                void'(dq.pop_front());
                resp_beat_done = 0;
                resp_log.push_back(h);
                pop_cyc = cyc;
                n_rsp++;
                if (resp_budget > 0) resp_budget--;
            end else begin
                resp_beat_done++;
            end
        end

        // apply request beat
        if (any && !stall && dev_req_ready) begin
            b = hq[g].pop_front();
            acc_log.push_back(g);
            acc_cyc.push_back(cyc);
            if (!eom) begin
                m_lock      = 1'b1;
                m_lock_host = g;
            end else begin
                m_lock = 1'b0;
                m_rr   = (g + 1) % N;
            end
            if (trk && eom) begin
                seq = int'(b.data[15:0]);
                nb  = rnd ? $urandom_range(1, 2) : 1;
                m_outq.push_back(g);
                exp_resp[g].push_back(seq);
                dq.push_back('{host: g, seq: seq, beats: nb});
                n_trk++;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        evaluate();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic run_idle(input string tag, input int limit);
        int n = 0;
        while (pending() && n < limit) begin
            cycle();
            n++;
        end
        check(tag, pending(), '0);
    endtask

    // Assert reset with inputs active; bench model is cleared to match
    task automatic do_reset(input int ncyc);
        nreset   = 1'b0;
        in_reset = 1'b1;
        for (int h = 0; h < N; h++) begin
            hq[h].delete();
            exp_resp[h].delete();
        end
        dq.delete();
        m_outq.delete();
        m_rr           = 0;
        m_lock         = 1'b0;
        m_lock_host    = 0;
        m_orphan       = 1'b0;
        resp_beat_done = 0;
        drive();
        repeat (ncyc) cycle();
        nreset   = 1'b1;
        in_reset = 1'b0;
        drive();
    endtask

    function automatic logic [4:0] pick_op();
        case ($urandom_range(0, 5))
            0:       return 5'h01;
            1:       return 5'h03;
            2:       return 5'h09;
            3:       return 5'h05;
            4:       return 5'h07;
            default: return 5'h0f;
        endcase
    endfunction

    function automatic int pick_len();
        int r = $urandom_range(0, 9);
        return (r < 6) ? 1 : (r < 9) ? 2 : 3;
    endfunction

    initial begin
        int gen;
        int cyc0;
        int trk0;
        int rsp0;
        cyc            = 0;
        n_trk          = 0;
        n_rsp          = 0;
        pop_cyc        = 0;
        rnd            = 1'b0;
        dreq_rdy       = 1'b1;
        inject_orphan  = 1'b0;
        resp_budget    = 0;
        for (int h = 0; h < N; h++) next_seq[h] = 0;
        host_req_dstaddr = '0;
        host_req_srcaddr = '0;
        host_req_data    = '0;
        do_reset(3);

        // four single-beat READs together: grants 0..3 back to back, responses in order
        clear_logs();
        for (int h = 0; h < N; h++) add_txn(h, 5'h01, 1);
        drive();
        repeat (6) cycle();
        check("t1_grant_count", acc_log.size(), 4);
        for (int i = 0; i < N; i++) check("t1_grant_order", qget(acc_log, i), i);
        check("t1_back_to_back", qget(acc_cyc, 3) - qget(acc_cyc, 0), 3);
        resp_budget = -1;
        run_idle("t1_drain", 50);
        for (int i = 0; i < N; i++) check("t1_resp_order", qget(resp_log, i), i);

        // 3-beat WRITE from host 1 with host 2 waiting: locked beats, one entry for host 1
        clear_logs();
        add_txn(1, 5'h03, 3);
        add_txn(2, 5'h01, 1);
        drive();
        run_idle("t2_drain", 50);
        check("t2_beat0", qget(acc_log, 0), 1);
        check("t2_beat1", qget(acc_log, 1), 1);
        check("t2_beat2", qget(acc_log, 2), 1);
        check("t2_next",  qget(acc_log, 3), 2);
        check("t2_consecutive", qget(acc_cyc, 2) - qget(acc_cyc, 0), 2);
        check("t2_resp_count", resp_log.size(), 2);
        check("t2_resp0", qget(resp_log, 0), 1);
        check("t2_resp1", qget(resp_log, 1), 2);

        // nine READs from host 0 with responses withheld: eighth fills, ninth stalls
        clear_logs();
        resp_budget = 0;
        for (int i = 0; i < 9; i++) add_txn(0, 5'h01, 1);
        drive();
        repeat (14) cycle();
        check("t3_accepted", acc_log.size(), DEPTH);
        check("t3_full_ready", host_req_ready[0], 1'b0);

        // POSTED from host 3 passes while the FIFO is full
        add_txn(3, 5'h05, 1);
        drive();
        repeat (3) cycle();
        check("t4_posted_taken", qget(acc_log, DEPTH), 3);
        check("t4_still_full", host_req_ready[0], 1'b0);

        // one response frees a slot; ninth READ goes the cycle the count drops
        resp_budget = 1;
        drive();
        repeat (4) cycle();
        check("t3_one_resp", resp_log.size(), 1);
        check("t3_released", acc_log.size(), DEPTH + 2);
        check("t3_release_timing", qget(acc_cyc, DEPTH + 1) - pop_cyc, 1);
        resp_budget = -1;
        run_idle("t3_drain", 100);

        // response with nothing outstanding: not accepted, sticky error until reset
        inject_orphan = 1'b1;
        drive();
        check("t5_orphan_ready", dev_resp_ready, 1'b0);
        check("t5_orphan_valid", host_resp_valid, '0);
        cycle();
        inject_orphan = 1'b0;
        drive();
        repeat (5) cycle();
        check("t5_orphan_sticky", orphan_err, 1'b1);
        do_reset(2);
        check("t5_orphan_cleared", orphan_err, 1'b0);

        // randomized traffic with throttling on every port
        rnd  = 1'b1;
        gen  = 0;
        cyc0 = cyc;
        trk0 = n_trk;
        rsp0 = n_rsp;
        while ((gen < NTXN || pending()) && (cyc - cyc0) < 60000) begin
            for (int h = 0; h < N; h++) begin
                if (gen < NTXN && hq[h].size() < 3) begin
                    add_txn(h, pick_op(), pick_len());
                    gen++;
                end
            end
            cycle();
        end
        check("rand_complete", (gen < NTXN) || pending(), '0);
        check("rand_resp_count", n_rsp - rsp0, n_trk - trk0);

        // reset in the middle of a burst: outputs low, priority back to host 0
        for (int h = 0; h < N; h++) begin
            add_txn(h, pick_op(), 3);
            add_txn(h, pick_op(), pick_len());
        end
        repeat (7) cycle();
        do_reset(3);
        rnd = 1'b0;
        clear_logs();
        for (int h = N - 1; h >= 0; h--) add_txn(h, 5'h01, 1);
        drive();
        cycle();
        check("t7_first_grant", qget(acc_log, 0), 0);
        run_idle("t7_drain", 100);
        check("t7_resp_order", qget(resp_log, 3), 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
